// File: rtl/sfif_rx_pkg.sv
// Shared types and constants for the RX capture FIFO unpacker.
// FSM encodings, DW0 decode bit positions and the skid entry layout.
package sfif_rx_pkg;

    localparam int unsigned DW_W  = 32;
    localparam int unsigned LEN_W = 11;

    localparam int unsigned FMT_4DW_BIT  = 29;
    localparam int unsigned FMT_DATA_BIT = 30;
    localparam int unsigned FMT_RSVD_BIT = 31;
    localparam int unsigned LEN_MSB      = 9;

    localparam logic [2:0] S_TS0  = 3'd0;
    localparam logic [2:0] S_TS1  = 3'd1;
    localparam logic [2:0] S_HDR0 = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_PAD  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    typedef struct packed {
        logic [DW_W-1:0]  data;
        logic             sop;
        logic             eop;
        logic [DW_W-1:0]  ts;
        logic [LEN_W-1:0] len;
    } sfif_word_t;

    localparam int unsigned WORD_W = $bits(sfif_word_t);

    // Payload DWs carried by a TLP; a zero length field means 1024.
    function automatic logic [LEN_W-1:0] pay_dw_of(input logic [DW_W-1:0] dw0);
        logic [LEN_W-1:0] pay;
        pay = '0;
        if (dw0[FMT_DATA_BIT]) begin
            pay = (dw0[LEN_MSB:0] == '0) ? LEN_W'(1024) : LEN_W'(dw0[LEN_MSB:0]);
        end
        return pay;
    endfunction

    function automatic logic [LEN_W-1:0] tlp_len_of(input logic [DW_W-1:0] dw0);
        return (dw0[FMT_4DW_BIT] ? LEN_W'(4) : LEN_W'(3)) + pay_dw_of(dw0);
    endfunction

endpackage

// File: rtl/sfif_rx_unpack_if.sv
// Framed TLP DW stream with per-TLP sideband, valid/ready handshake.
interface sfif_rx_unpack_if;
    import sfif_rx_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [DW_W-1:0]  out_data;
    logic             out_sop;
    logic             out_eop;
    logic [DW_W-1:0]  tlp_ts;
    logic [LEN_W-1:0] tlp_len;

    modport master (
        output out_valid, out_data, out_sop, out_eop, tlp_ts, tlp_len,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_sop, out_eop, tlp_ts, tlp_len,
        output out_ready
    );

endinterface

// File: rtl/sfif_skid2.sv
// Two-entry valid/ready buffer. Upstream never pushes into a full buffer, so
// there is no input ready; occupancy is exported for credit accounting.
module sfif_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic         v1;
    logic [W-1:0] d1;
    logic         pop;

    assign pop       = out_valid & out_ready;
    assign occupancy = 2'(out_valid) + 2'(v1);

    // Head entry drives the output directly; second entry only fills behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            v1        <= 1'b0;
            d1        <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end else begin
                        v1 <= 1'b1;
                        d1 <= in_data;
                    end
                end
                2'b01: begin
                    out_data  <= d1;
                    out_valid <= v1;
                    v1        <= 1'b0;
                end
                2'b11: begin
                    if (v1) begin
                        out_data <= d1;
                        d1       <= in_data;
                    end else begin
                        out_data <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sfif_rx_unpack.sv
// Drains the RX capture FIFO, strips timestamp and pad words from each record
// and emits the TLP DWs as a framed stream with timestamp/length sideband.
module sfif_rx_unpack
    import sfif_rx_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               wb_clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [DW_W-1:0]    rx32_data,
    output logic               rden,
    sfif_rx_unpack_if.master   st,
    output logic [CNT_W-1:0]   tlp_cnt,
    output logic [CNT_W-1:0]   dw_cnt,
    output logic               fmt_err,
    input  logic               clr
);

    logic [2:0]       state, state_nxt;
    logic             word_vld;
    logic [1:0]       hdr_left, hdr_left_nxt;
    logic [LEN_W-1:0] pay_left, pay_left_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [DW_W-1:0]  ts_q, ts_nxt;
    logic             fmt_err_nxt;
    logic             push;
    sfif_word_t       push_word;
    sfif_word_t       head;
    logic [WORD_W-1:0] head_bits;
    logic [1:0]       occ;
    logic [1:0]       credits_used;
    logic             acc;

    assign acc = st.out_valid & st.out_ready;

    // Credits are counted after this cycle's pop so a draining stream keeps 1 DW/cycle.
    assign credits_used = occ - 2'(acc) + 2'(word_vld);
    assign rden         = ~empty & (credits_used < 2'd2) & (state != S_ERR);

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) begin
            state    <= S_TS0;
            word_vld <= 1'b0;
            hdr_left <= '0;
            pay_left <= '0;
            len_q    <= '0;
            ts_q     <= '0;
            fmt_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_vld <= rden & ~empty;
            hdr_left <= hdr_left_nxt;
            pay_left <= pay_left_nxt;
            len_q    <= len_nxt;
            ts_q     <= ts_nxt;
            fmt_err  <= fmt_err_nxt;
        end
    end

    // Record parser: advances once per FIFO word returned.
    always_comb begin
        state_nxt    = state;
        hdr_left_nxt = hdr_left;
        pay_left_nxt = pay_left;
        len_nxt      = len_q;
        ts_nxt       = ts_q;
        fmt_err_nxt  = fmt_err;
        push         = 1'b0;
        push_word    = '{data: rx32_data, sop: 1'b0, eop: 1'b0, ts: ts_q, len: len_q};

        if (clr) begin
            state_nxt   = S_TS0;
            fmt_err_nxt = 1'b0;
        end else if (word_vld) begin
            case (state)
                S_TS0: begin
                    ts_nxt    = rx32_data;
                    state_nxt = S_TS1;
                end
                S_TS1: state_nxt = S_HDR0;
                S_HDR0: begin
                    if (rx32_data[FMT_RSVD_BIT]) begin
                        state_nxt   = S_ERR;
                        fmt_err_nxt = 1'b1;
                    end else begin
                        len_nxt       = tlp_len_of(rx32_data);
                        hdr_left_nxt  = rx32_data[FMT_4DW_BIT] ? 2'd3 : 2'd2;
                        pay_left_nxt  = pay_dw_of(rx32_data);
                        push          = 1'b1;
                        push_word.sop = 1'b1;
                        push_word.len = len_nxt;
                        state_nxt     = S_HDR;
                    end
                end
                S_HDR: begin
                    push         = 1'b1;
                    hdr_left_nxt = hdr_left - 2'd1;
                    if (hdr_left == 2'd1) begin
                        if (pay_left == '0) begin
                            push_word.eop = 1'b1;
                            state_nxt     = len_q[0] ? S_PAD : S_TS0;
                        end else begin
                            state_nxt = S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    push         = 1'b1;
                    pay_left_nxt = pay_left - LEN_W'(1);
                    if (pay_left == LEN_W'(1)) begin
                        push_word.eop = 1'b1;
                        state_nxt     = len_q[0] ? S_PAD : S_TS0;
                    end
                end
                S_PAD:   state_nxt = S_TS0;
                S_ERR:   ;
                default: state_nxt = S_TS0;
            endcase
        end
    end

    sfif_skid2 #(.W(WORD_W)) u_skid (
        .clk       (wb_clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (push_word),
        .out_valid (st.out_valid),
        .out_ready (st.out_ready),
        .out_data  (head_bits),
        .occupancy (occ)
    );

    assign head        = sfif_word_t'(head_bits);
    assign st.out_data = head.data;
    assign st.out_sop  = head.sop;
    assign st.out_eop  = head.eop;
    assign st.tlp_ts   = head.ts;
    assign st.tlp_len  = head.len;

    // Saturating statistics; clr wins over a same-cycle increment.
    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) begin
            tlp_cnt <= '0;
            dw_cnt  <= '0;
        end else if (clr) begin
            tlp_cnt <= '0;
            dw_cnt  <= '0;
        end else if (acc) begin
            if (dw_cnt != '1) begin
                dw_cnt <= dw_cnt + CNT_W'(1);
            end
            if (st.out_eop && (tlp_cnt != '1)) begin
                tlp_cnt <= tlp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sfif_rx_unpack.sv
// Bench for sfif_rx_unpack: FIFO model, record builder with expected-word queue,
// directed vector table, randomized mixed TLPs, format error and mid-record reset.
module tb_sfif_rx_unpack;
    import sfif_rx_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned MEM_D = 8192;

    logic              wb_clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              empty;
    logic              rden;
    logic [31:0]       rx32_data = '0;
    logic [CNT_W-1:0]  tlp_cnt;
    logic [CNT_W-1:0]  dw_cnt;
    logic              fmt_err;

    sfif_rx_unpack_if st();

    sfif_rx_unpack #(.CNT_W(CNT_W)) dut (
        .wb_clk    (wb_clk),
        .rst       (rst),
        .empty     (empty),
        .rx32_data (rx32_data),
        .rden      (rden),
        .st        (st),
        .tlp_cnt   (tlp_cnt),
        .dw_cnt    (dw_cnt),
        .fmt_err   (fmt_err),
        .clr       (clr)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [31:0] ts;
        logic [10:0] len;
    } exp_t;

    typedef struct {
        logic [31:0] ts;
        logic [31:0] dw0;
        int          exp_len;
        int          exp_reads;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] mem [MEM_D];
    bit          fwd [MEM_D];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          fifo_flush = 1'b0;
    int          n_reads = 0;
    int          fwd_read_cnt = 0;
    int          cyc = 0;
    bit          last_read = 1'b0;
    bit          last_fwd = 1'b0;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int exp_tlp = 0;
    int exp_dw = 0;
    int sop_cyc = 0;
    int eop_cyc = 0;
    int credit_viol = 0;
    int rdy_pct = 100;
    bit chk_credit = 1'b0;

    assign empty = (rd_ptr == wr_ptr);

    // Capture FIFO with one-cycle read latency.
    always @(posedge wb_clk) begin
        cyc <= cyc + 1;
        if (fifo_flush) begin
            rd_ptr    <= wr_ptr;
            last_read <= 1'b0;
        end else if (rden && !empty) begin
            rx32_data    <= mem[rd_ptr];
            last_fwd     <= fwd[rd_ptr];
            fwd_read_cnt <= fwd_read_cnt + (fwd[rd_ptr] ? 1 : 0);
            n_reads      <= n_reads + 1;
            rd_ptr       <= rd_ptr + 1;
            last_read    <= 1'b1;
        end else begin
            last_read <= 1'b0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] d, input bit is_fwd, input bit gaps);
        mem[wr_ptr] = d;
        fwd[wr_ptr] = is_fwd;
        wr_ptr++;
        if (gaps && ($urandom_range(0, 3) == 0)) @(negedge wb_clk);
    endtask

    // Builds one FIFO record and the words the stream must carry for it.
    task automatic send_tlp(input logic [31:0] ts, input logic [31:0] dw0, input bit gaps);
        int hdr;
        int pay;
        int tot;
        logic [31:0] d;
        exp_t e;
        hdr = dw0[29] ? 4 : 3;
        pay = 0;
        if (dw0[30]) pay = (dw0[9:0] == '0) ? 1024 : int'(dw0[9:0]);
        tot = hdr + pay;
        write_word(ts, 1'b0, gaps);
        write_word(ts, 1'b0, gaps);
        for (int i = 0; i < tot; i++) begin
            d      = (i == 0) ? dw0 : $urandom;
            e.data = d;
            e.sop  = (i == 0);
            e.eop  = (i == tot - 1);
            e.ts   = ts;
            e.len  = 11'(tot);
            exp_q.push_back(e);
            write_word(d, 1'b1, gaps);
        end
        if ((tot % 2) == 1) write_word($urandom, 1'b0, gaps);
        exp_tlp++;
        exp_dw += tot;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && n < budget) begin
            @(negedge wb_clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_drain: got %0d words outstanding need 0", name, exp_q.size());
        end
        repeat (4) @(negedge wb_clk);
    endtask

    vec_t vt[5];

    initial begin
        int r0;
        int a0;
        int w0;
        int n;
        int rd_seen;
        logic [31:0] dw0;

        vt[0] = '{ts: 32'h1234_5678, dw0: 32'h0000_0001, exp_len: 3,    exp_reads: 6};
        vt[1] = '{ts: 32'hCAFE_0001, dw0: 32'h6000_0002, exp_len: 6,    exp_reads: 8};
        vt[2] = '{ts: 32'h0BAD_F00D, dw0: 32'h4000_0000, exp_len: 1027, exp_reads: 1030};
        vt[3] = '{ts: 32'h5555_AAAA, dw0: 32'h2000_0000, exp_len: 4,    exp_reads: 6};
        vt[4] = '{ts: 32'h0F0F_F0F0, dw0: 32'h4000_0001, exp_len: 4,    exp_reads: 6};

        rst = 1'b1;
        clr = 1'b0;
        st.out_ready = 1'b0;

        // Output side: drive ready, check every accepted word against the model.
        fork
            forever begin
                exp_t e;
                exp_t got;
                @(negedge wb_clk);
                st.out_ready = (rdy_pct >= 100) || (int'($urandom_range(0, 99)) < rdy_pct);
                #1;
                if (chk_credit && ((fwd_read_cnt - acc_cnt + ((last_read && !last_fwd) ? 1 : 0)) > 2))
                    credit_viol++;
                if (st.out_valid && st.out_ready) begin
                    acc_cnt++;
                    total++;
                    got = '{data: st.out_data, sop: st.out_sop, eop: st.out_eop,
                            ts: st.tlp_ts, len: st.tlp_len};
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL word: got unexpected data=%h need none", st.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL word: got d=%h s=%b e=%b ts=%h len=%0d need d=%h s=%b e=%b ts=%h len=%0d",
                                     got.data, got.sop, got.eop, got.ts, got.len,
                                     e.data, e.sop, e.eop, e.ts, e.len);
                        end
                        if (e.sop) sop_cyc = cyc;
                        if (e.eop) eop_cyc = cyc;
                    end
                end
            end
        join_none

        repeat (3) @(negedge wb_clk);
        chk("rst_out_valid", 64'(st.out_valid), 0);
        chk("rst_out_sop",   64'(st.out_sop), 0);
        chk("rst_out_eop",   64'(st.out_eop), 0);
        chk("rst_out_data",  64'(st.out_data), 0);
        chk("rst_tlp_ts",    64'(st.tlp_ts), 0);
        chk("rst_tlp_len",   64'(st.tlp_len), 0);
        chk("rst_tlp_cnt",   64'(tlp_cnt), 0);
        chk("rst_dw_cnt",    64'(dw_cnt), 0);
        chk("rst_fmt_err",   64'(fmt_err), 0);
        chk("rst_rden",      64'(rden), 0);
        rst = 1'b0;
        @(negedge wb_clk);

        // Directed records, full-rate output.
        for (int i = 0; i < 5; i++) begin
            r0 = n_reads;
            a0 = acc_cnt;
            send_tlp(vt[i].ts, vt[i].dw0, 1'b0);
            wait_drain($sformatf("vec%0d", i), 3000);
            chk($sformatf("vec%0d_words", i), 64'(acc_cnt - a0), 64'(vt[i].exp_len));
            chk($sformatf("vec%0d_reads", i), 64'(n_reads - r0), 64'(vt[i].exp_reads));
            chk($sformatf("vec%0d_span", i), 64'(eop_cyc - sop_cyc), 64'(vt[i].exp_len - 1));
            chk($sformatf("vec%0d_tlp_cnt", i), 64'(tlp_cnt), 64'(exp_tlp));
            chk($sformatf("vec%0d_dw_cnt", i), 64'(dw_cnt), 64'(exp_dw));
        end

        // Random mixed TLPs, 50% ready, FIFO running dry mid-record.
        rdy_pct    = 50;
        chk_credit = 1'b1;
        r0 = n_reads;
        w0 = wr_ptr;
        for (int i = 0; i < 20; i++) begin
            dw0 = {1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   19'($urandom), 10'($urandom_range(1, 12))};
            send_tlp($urandom, dw0, 1'b1);
        end
        wait_drain("rand", 20000);
        chk("rand_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
        chk("rand_dw_cnt",  64'(dw_cnt), 64'(exp_dw));
        chk("rand_reads",   64'(n_reads - r0), 64'(wr_ptr - w0));
        chk("rand_credit",  64'(credit_viol), 0);
        chk_credit = 1'b0;

        // Reserved format: parser halts until clr.
        rdy_pct = 100;
        r0 = n_reads;
        a0 = acc_cnt;
        write_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        write_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        write_word(32'h8000_0000, 1'b0, 1'b0);
        repeat (10) @(negedge wb_clk);
        chk("err_fmt_err", 64'(fmt_err), 1);
        chk("err_reads", 64'(n_reads - r0), 3);
        exp_tlp = 0;
        exp_dw  = 0;
        send_tlp(32'h7777_0000, 32'h4000_0002, 1'b0);
        rd_seen = 0;
        repeat (12) begin
            @(negedge wb_clk);
            if (rden) rd_seen++;
        end
        chk("err_rden_held", 64'(rd_seen), 0);
        chk("err_no_output", 64'(acc_cnt - a0), 0);
        clr = 1'b1;
        @(negedge wb_clk);
        clr = 1'b0;
        chk("clr_fmt_err", 64'(fmt_err), 0);
        chk("clr_tlp_cnt", 64'(tlp_cnt), 0);
        chk("clr_dw_cnt",  64'(dw_cnt), 0);
        wait_drain("clr", 300);
        chk("clr_resume_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
        chk("clr_resume_dw_cnt",  64'(dw_cnt), 64'(exp_dw));

        // Reset in the middle of a payload.
        rdy_pct = 50;
        send_tlp(32'h3141_5926, 32'h6000_0010, 1'b0);
        a0 = acc_cnt;
        n  = 0;
        while ((acc_cnt - a0) < 8 && n < 500) begin
            @(negedge wb_clk);
            n++;
        end
        chk("rst_mid_progress", 64'((acc_cnt - a0) >= 8), 1);
        rst        = 1'b1;
        fifo_flush = 1'b1;
        exp_q.delete();
        @(negedge wb_clk);
        chk("rst_mid_out_valid", 64'(st.out_valid), 0);
        chk("rst_mid_rden",      64'(rden), 0);
        chk("rst_mid_tlp_cnt",   64'(tlp_cnt), 0);
        chk("rst_mid_dw_cnt",    64'(dw_cnt), 0);
        rst        = 1'b0;
        fifo_flush = 1'b0;
        rdy_pct    = 100;
        exp_tlp    = 0;
        exp_dw     = 0;
        @(negedge wb_clk);
        send_tlp(32'h2718_2818, 32'h6000_0003, 1'b0);
        wait_drain("post_rst", 300);
        chk("post_rst_tlp_cnt", 64'(tlp_cnt), 64'(exp_tlp));
        chk("post_rst_dw_cnt",  64'(dw_cnt), 64'(exp_dw));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
